// File: rtl/exe_alu_issue_pkg.sv
// rtl/exe_alu_issue_pkg.sv - shared ALU op bit indices, op width and issue-state enum
package exe_alu_issue_pkg;

  localparam int OP_W = 19;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
  localparam int ALU_MUL  = 12;
  localparam int ALU_MULH = 13;
  localparam int ALU_MULHU = 14;
  localparam int ALU_DIV  = 15;
  localparam int ALU_DIVU = 16;
  localparam int ALU_MOD  = 17;
  localparam int ALU_MODU = 18;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/exe_stall_cnt.sv
// rtl/exe_stall_cnt.sv - free-running count of ALU stall cycles, cleared only by reset
module exe_stall_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/exe_alu_issue.sv
// rtl/exe_alu_issue.sv - execute-stage issue controller between decode register and ALU
// Optional stall_cnt output and exe_stall_cnt instance enabled by EXE_STALL_CNT_EN.
module exe_alu_issue #(
  parameter int OP_W   = exe_alu_issue_pkg::OP_W,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_to_es_valid,
  output logic              es_allowin,
  input  logic [OP_W-1:0]   ds_alu_op,
  input  logic [DATA_W-1:0] ds_src1,
  input  logic [DATA_W-1:0] ds_src2,
  input  logic [TAG_W-1:0]  ds_tag,
  input  logic              flush,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_complete,
  output logic              es_to_ms_valid,
  input  logic              ms_allowin,
  output logic [DATA_W-1:0] es_result,
`ifdef EXE_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [TAG_W-1:0]  es_tag
);

  import exe_alu_issue_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] res_q;
  logic              accept;
  logic              capture;

  assign accept  = ds_to_es_valid && es_allowin;
  assign capture = !flush && (state_q == ST_BUSY) && alu_complete && !ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_BUSY;
        ST_BUSY: begin
          if (alu_complete) begin
            if (ms_allowin) state_d = accept ? ST_BUSY : ST_EMPTY;
            else            state_d = ST_HOLD;
          end
        end
        ST_HOLD: if (ms_allowin) state_d = accept ? ST_BUSY : ST_EMPTY;
        ST_DRAIN: state_d = ST_EMPTY;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Operands stay on the ALU inputs in every state; only the op enable is gated.
  always_comb begin
    es_allowin     = 1'b0;
    es_to_ms_valid = 1'b0;
    alu_op         = '0;
    es_result      = '0;
    case (state_q)
      ST_EMPTY: es_allowin = 1'b1;
      ST_BUSY: begin
        alu_op         = op_q;
        es_result      = alu_result;
        es_to_ms_valid = alu_complete;
        es_allowin     = alu_complete && ms_allowin;
      end
      ST_HOLD: begin
        es_result      = res_q;
        es_to_ms_valid = 1'b1;
        es_allowin     = ms_allowin;
      end
      default: es_allowin = 1'b0;
    endcase
    if (flush) es_allowin = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      tag_q  <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= ds_alu_op;
        src1_q <= ds_src1;
        src2_q <= ds_src2;
        tag_q  <= ds_tag;
      end
      if (capture) begin
        res_q <= alu_result;
      end
    end
  end

  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;
  assign es_tag   = tag_q;

`ifdef EXE_STALL_CNT_EN
  logic stall_inc;

  assign stall_inc = (state_q == ST_BUSY) && !alu_complete;

  exe_stall_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_exe_alu_issue.sv
// tb/tb_exe_alu_issue.sv - directed self-checking bench for exe_alu_issue with a behavioural ALU
module tb_exe_alu_issue;
  import exe_alu_issue_pkg::*;

  localparam int DW = 32;
  localparam int TW = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic          ds_to_es_valid;
  logic          es_allowin;
  logic [OP_W-1:0] ds_alu_op;
  logic [DW-1:0] ds_src1;
  logic [DW-1:0] ds_src2;
  logic [TW-1:0] ds_tag;
  logic          flush;
  logic [OP_W-1:0] alu_op;
  logic [DW-1:0] alu_src1;
  logic [DW-1:0] alu_src2;
  logic [DW-1:0] alu_result;
  logic          alu_complete;
  logic          es_to_ms_valid;
  logic          ms_allowin;
  logic [DW-1:0] es_result;
  logic [TW-1:0] es_tag;
`ifdef EXE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif
  logic          mc_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exe_alu_issue #(.OP_W(OP_W), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_alu_op      (ds_alu_op),
    .ds_src1        (ds_src1),
    .ds_src2        (ds_src2),
    .ds_tag         (ds_tag),
    .flush          (flush),
    .alu_op         (alu_op),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_result     (alu_result),
    .alu_complete   (alu_complete),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allowin     (ms_allowin),
    .es_result      (es_result),
`ifdef EXE_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .es_tag         (es_tag)
  );

  // Behavioural ALU: divides/mods wait for mc_done, everything else is single-cycle.
  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD])      alu_result = alu_src1 + alu_src2;
    else if (alu_op[ALU_SUB]) alu_result = alu_src1 - alu_src2;
    else if (alu_op[ALU_XOR]) alu_result = alu_src1 ^ alu_src2;
    else if (alu_op[ALU_DIV] || alu_op[ALU_DIVU])
      alu_result = (alu_src2 != '0) ? alu_src1 / alu_src2 : '1;
    else if (alu_op[ALU_MOD] || alu_op[ALU_MODU])
      alu_result = (alu_src2 != '0) ? alu_src1 % alu_src2 : alu_src1;
    alu_complete = (alu_op[ALU_DIV] || alu_op[ALU_DIVU] || alu_op[ALU_MOD] || alu_op[ALU_MODU])
                   ? mc_done : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int op_bit, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] t);
    ds_to_es_valid = 1'b1;
    ds_alu_op      = '0;
    ds_alu_op[op_bit] = 1'b1;
    ds_src1        = a;
    ds_src2        = b;
    ds_tag         = t;
  endtask

  logic [OP_W-1:0] op_div;
  logic [OP_W-1:0] op_divu;
  logic [DW-1:0]   xa [4];
  logic [DW-1:0]   xb [4];
  logic [DW-1:0]   xr [4];

  initial begin
    op_div  = '0; op_div[ALU_DIV]   = 1'b1;
    op_divu = '0; op_divu[ALU_DIVU] = 1'b1;
    xa[0] = 32'hF0; xb[0] = 32'h0F; xr[0] = 32'hFF;
    xa[1] = 32'hFF; xb[1] = 32'h01; xr[1] = 32'hFE;
    xa[2] = 32'h12; xb[2] = 32'h34; xr[2] = 32'h26;
    xa[3] = 32'hA5; xb[3] = 32'h0F; xr[3] = 32'hAA;

    reset = 1'b1; ds_to_es_valid = 1'b0; ds_alu_op = '0; ds_src1 = '0; ds_src2 = '0;
    ds_tag = '0; flush = 1'b0; ms_allowin = 1'b1; mc_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin", es_allowin, 1);
    chk("rst_valid", es_to_ms_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_src1", alu_src1, 0);
    chk("rst_src2", alu_src2, 0);
    chk("rst_result", es_result, 0);
    chk("rst_tag", es_tag, 0);

    // ADD 3+4, downstream ready
    offer(ALU_ADD, 3, 4, 38'h11);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("add_valid", es_to_ms_valid, 1);
    chk("add_result", es_result, 7);
    chk("add_tag", es_tag, 38'h11);
    chk("add_allowin", es_allowin, 1);
    tick();
    chk("add_empty_valid", es_to_ms_valid, 0);
    chk("add_empty_allowin", es_allowin, 1);

    // DIV 100/7 with 33 stall cycles
    offer(ALU_DIV, 100, 7, 38'h22);
    tick();
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      #1;
      chk("div_op", alu_op, op_div);
      chk("div_src1", alu_src1, 100);
      chk("div_src2", alu_src2, 7);
      chk("div_allowin", es_allowin, 0);
      chk("div_valid", es_to_ms_valid, 0);
      tick();
    end
    mc_done = 1'b1;
    #1;
    chk("div_done_valid", es_to_ms_valid, 1);
    chk("div_result", es_result, 14);
    chk("div_tag", es_tag, 38'h22);
`ifdef EXE_STALL_CNT_EN
    chk("div_stall_cnt", stall_cnt, 33);
`endif
    tick();
    mc_done = 1'b0;

    // ADD 5+5 with downstream stalled for 3 cycles
    ms_allowin = 1'b0;
    offer(ALU_ADD, 5, 5, 38'h33);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("bp_busy_valid", es_to_ms_valid, 1);
    chk("bp_busy_result", es_result, 10);
    chk("bp_busy_allowin", es_allowin, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_alu_op", alu_op, 0);
      chk("hold_result", es_result, 10);
      chk("hold_valid", es_to_ms_valid, 1);
      chk("hold_allowin", es_allowin, 0);
    end
    tick();
    ms_allowin = 1'b1;
    offer(ALU_ADD, 1, 2, 38'h34);
    #1;
    chk("release_allowin", es_allowin, 1);
    chk("release_result", es_result, 10);
    chk("release_tag", es_tag, 38'h33);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("after_hold_result", es_result, 3);
    chk("after_hold_tag", es_tag, 38'h34);
    tick();

    // Flush at cycle 10 of DIVU, then SUB 9-2
    offer(ALU_DIVU, 50, 5, 38'h40);
    tick();
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_allowin", es_allowin, 0);
    chk("flush_alu_op", alu_op, op_divu);
    tick();
    flush = 1'b0;
    offer(ALU_SUB, 9, 2, 38'h44);
    #1;
    chk("drain_alu_op", alu_op, 0);
    chk("drain_allowin", es_allowin, 0);
    chk("drain_valid", es_to_ms_valid, 0);
    chk("drain_src1", alu_src1, 50);
`ifdef EXE_STALL_CNT_EN
    chk("drain_stall_cnt", stall_cnt, 43);
`endif
    tick();
    chk("post_drain_allowin", es_allowin, 1);
    chk("post_drain_valid", es_to_ms_valid, 0);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("sub_valid", es_to_ms_valid, 1);
    chk("sub_result", es_result, 7);
    chk("sub_tag", es_tag, 38'h44);
    tick();

    // Reset in the middle of MOD
    offer(ALU_MOD, 17, 5, 38'h55);
    tick();
    ds_to_es_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_allowin", es_allowin, 1);
    chk("mrst_valid", es_to_ms_valid, 0);
    chk("mrst_alu_op", alu_op, 0);
    chk("mrst_src1", alu_src1, 0);
    chk("mrst_src2", alu_src2, 0);
    chk("mrst_result", es_result, 0);
    chk("mrst_tag", es_tag, 0);
`ifdef EXE_STALL_CNT_EN
    chk("mrst_stall_cnt", stall_cnt, 0);
`endif
    tick();
    chk("mrst_no_offer", es_to_ms_valid, 0);

    // Four back-to-back XORs
    offer(ALU_XOR, xa[0], xb[0], 38'd1);
    tick();
    for (int i = 1; i < 4; i++) begin
      offer(ALU_XOR, xa[i], xb[i], TW'(i + 1));
      #1;
      chk("b2b_valid", es_to_ms_valid, 1);
      chk("b2b_allowin", es_allowin, 1);
      chk("b2b_result", es_result, xr[i-1]);
      chk("b2b_tag", es_tag, TW'(i));
      tick();
    end
    ds_to_es_valid = 1'b0;
    #1;
    chk("b2b_last_valid", es_to_ms_valid, 1);
    chk("b2b_last_result", es_result, xr[3]);
    chk("b2b_last_tag", es_tag, 38'd4);
    tick();
    chk("b2b_idle_valid", es_to_ms_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_alu_issue.md
# exe_alu_issue

Execute-stage issue controller that sits between the decode-to-execute pipeline register and the ALU. It accepts one decoded operation at a time and drives the ALU's op and operand inputs. It holds those inputs stable until the ALU raises `complete`. It then delivers the result to the memory stage over the valid/allowin pipeline handshake, capturing the result when the downstream stage back-pressures.

## Interface
- `OP_W`, 19, width of the one-hot ALU op vector
- `DATA_W`, 32, operand/result width
- `TAG_W`, 38, opaque side-band (dest, gr_we, pc) carried alongside the op

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `ds_to_es_valid`  in  1  decode stage offers an operation
- `es_allowin`  out  1  this stage accepts an operation this cycle
- `ds_alu_op`  in  OP_W  one-hot op (all-zero = no ALU work)
- `ds_src1`, `ds_src2`  in  DATA_W  operands
- `ds_tag`  in  TAG_W  side-band
- `flush`  in  1  cancel in-flight operation (exception/branch)
- `alu_op`  out  OP_W  to ALU
- `alu_src1`, `alu_src2`  out  DATA_W  to ALU
- `alu_result`  in  DATA_W  from ALU
- `alu_complete`  in  1  from ALU; high when the current op's result is valid (combinational for single-cycle ops)
- `es_to_ms_valid`  out  1  result offered to memory stage
- `ms_allowin`  in  1  memory stage accepts
- `es_result`  out  DATA_W  result
- `es_tag`  out  TAG_W  side-band of the offered result

## Operation
- States: EMPTY, BUSY (op driven to ALU), HOLD (result captured, waiting for `ms_allowin`), DRAIN (one idle cycle after flush).
- Accept = `ds_to_es_valid && es_allowin`; it latches op, srcs and tag into the stage register.
- `es_allowin` = !flush && (EMPTY || (BUSY && alu_complete && ms_allowin) || (HOLD && ms_allowin)). It is 0 in DRAIN.
- `alu_op` = latched op in BUSY, else all-zero. `alu_src1`/`alu_src2` = latched operands in all states, changing only on accept.
- `es_to_ms_valid` = (BUSY && alu_complete) || HOLD.
- `es_result` = `alu_result` in BUSY, captured register in HOLD.
- Transitions:
  - EMPTY→BUSY on accept.
  - BUSY && alu_complete && ms_allowin → BUSY if accept, else EMPTY.
  - BUSY && alu_complete && !ms_allowin → HOLD; capture `alu_result`.
  - HOLD && ms_allowin → BUSY if accept, else EMPTY.
  - BUSY && !alu_complete → stay.
- Flush (any state) → DRAIN next cycle, then DRAIN→EMPTY. `flush` has priority over accept and completion; an offered result in the flush cycle is still visible combinationally, but the downstream stage must also qualify on `flush`.
- DRAIN drives `alu_op`=0 for one full cycle so a partially run divide sees its enable drop before any new op.
- Zero op: ALU reports complete immediately, and the result passes through as 0.

## Timing
- Reset values: state EMPTY, `es_allowin`=1, `es_to_ms_valid`=0, `alu_op`=0, `alu_src1`/`alu_src2`=0, `es_result`=0, `es_tag`=0.
- Single-cycle op: accepted at edge N, offered during cycle N→N+1; no added latency.
- Multi-cycle op: offered in the first cycle `alu_complete`=1. The op is held unchanged through every stall cycle.
- Back-to-back single-cycle ops sustain one per cycle when `ms_allowin`=1.
- Reset mid-divide: state EMPTY next cycle, and `alu_op`=0.

## Configuration
- `EXE_STALL_CNT_EN` defined: adds output `stall_cnt` (32-bit).
  - It increments each cycle in BUSY with `alu_complete`=0, and wraps at 2^32.
  - It clears on reset only.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - ALU op bit indices: ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, NOR=5, OR=6, XOR=7, SLL=8, SRL=9, SRA=10, LUI=11, MUL=12, MULH=13, MULHU=14, DIV=15, DIVU=16, MOD=17, MODU=18.
  - `OP_W`.
  - The state enum.
- One natural sub-module, `exe_stall_cnt`, instantiated only under the macro.

## Test plan
- ADD 3+4, ms_allowin=1 → `es_to_ms_valid`=1 the cycle after accept, `es_result`=7; `es_allowin` stays 1.
- DIV 100/7, ALU complete low for 33 cycles → `alu_op` bit 15 and srcs stable throughout, `es_allowin`=0. Offer occurs with `es_result`=14, and `stall_cnt`=33 when enabled.
- ADD 5+5 with ms_allowin=0 for 3 cycles → HOLD, `alu_op`=0, `es_result`=10 held. It is released in the cycle ms_allowin rises, and a new op is accepted the same cycle.
- Flush at cycle 10 of DIVU → DRAIN one cycle with `alu_op`=0, `es_allowin`=0. Then EMPTY, and the next op (SUB 9-2) yields 7.
- Reset asserted mid-MOD → next cycle all outputs at reset values, and no result is offered.
- Four back-to-back XOR ops (0xF0^0x0F, …) with ms_allowin=1 → four consecutive offered results, one per cycle, with tags in order.
